// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion on
// flush or hazard, and a full freeze while the EX stage is held.
module id_ex_hazard_stage #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ALU_OP_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_AW-1:0]   id_rs,
   input  logic [REG_AW-1:0]   id_rt,
   input  logic                id_uses_rt,
   input  logic [REG_AW-1:0]   id_write_reg,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                id_mem_write,
   input  logic [ALU_OP_W-1:0] id_alu_op,
   input  logic [DATA_W-1:0]   id_rs_data,
   input  logic [DATA_W-1:0]   id_rt_data,
   input  logic [DATA_W-1:0]   id_imm,
   input  logic                flush,
   input  logic                ex_hold,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                ex_valid,
   output logic [REG_AW-1:0]   ex_rs,
   output logic [REG_AW-1:0]   ex_rt,
   output logic [REG_AW-1:0]   ex_write_reg,
   output logic                ex_reg_write,
   output logic                ex_mem_read,
   output logic                ex_mem_write,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic [DATA_W-1:0]   ex_rs_data,
   output logic [DATA_W-1:0]   ex_rt_data,
   output logic [DATA_W-1:0]   ex_imm,
   output logic [CNT_W-1:0]    bubble_cnt
);

   logic flush_pend;
   logic load_use;
   logic take_bubble;
   logic take_id;

   // The hazard compares against the instruction already in EX, not the one
   // arriving from decode; a load into $zero never stalls.
   assign load_use = ex_valid & ex_mem_read & (ex_write_reg != '0) & id_valid &
                     ((ex_write_reg == id_rs) | (id_uses_rt & (ex_write_reg == id_rt)));

   assign take_bubble = ~ex_hold & (flush | flush_pend | load_use);
   assign take_id     = ~ex_hold & ~take_bubble & id_valid;

   // Stall interface: pc_write/if_id_write low means the upstream stage must
   // hold its contents this cycle; a pending redirect overrides a load-use stall.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if (rst) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end else if (ex_hold) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (flush | flush_pend) begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_pend   <= 1'b0;
         bubble_cnt   <= '0;
         ex_valid     <= 1'b0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_write_reg <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_op    <= '0;
         ex_rs_data   <= '0;
         ex_rt_data   <= '0;
         ex_imm       <= '0;
      end else if (ex_hold) begin
         // A flush arriving during a hold must still squash once EX frees up.
         if (flush) flush_pend <= 1'b1;
      end else begin
         flush_pend <= 1'b0;
         if (take_bubble && (bubble_cnt != {CNT_W{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
         ex_valid     <= take_id;
         ex_rs        <= take_id ? id_rs        : '0;
         ex_rt        <= take_id ? id_rt        : '0;
         ex_write_reg <= take_id ? id_write_reg : '0;
         ex_reg_write <= take_id & id_reg_write;
         ex_mem_read  <= take_id & id_mem_read;
         ex_mem_write <= take_id & id_mem_write;
         ex_alu_op    <= take_id ? id_alu_op    : '0;
         ex_rs_data   <= take_id ? id_rs_data   : '0;
         ex_rt_data   <= take_id ? id_rt_data   : '0;
         ex_imm       <= take_id ? id_imm       : '0;
      end
   end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: a cycle model predicts the EX
// register state into a queue and every edge's DUT state is popped and compared.
module tb_id_ex_hazard_stage;

   localparam int SW = 135;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
   logic [4:0]  id_rs, id_rt, id_write_reg;
   logic [3:0]  id_alu_op;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        flush, ex_hold;
   logic        pc_write, if_id_write, ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_write_reg;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [15:0] bubble_cnt;

   id_ex_hazard_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_write_reg(id_write_reg), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .flush(flush), .ex_hold(ex_hold), .pc_write(pc_write), .if_id_write(if_id_write),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int checks = 0;
   int errors = 0;
   logic [SW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model of the EX register state
   logic        m_valid, m_rw, m_mr, m_mw, m_fp;
   logic [4:0]  m_rs, m_rt, m_wr;
   logic [3:0]  m_alu;
   logic [31:0] m_rsd, m_rtd, m_imm;
   logic [15:0] m_cnt;

   function automatic logic [SW-1:0] dut_state();
      return {ex_valid, ex_rs, ex_rt, ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write,
              ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, bubble_cnt};
   endfunction

   function automatic logic [SW-1:0] model_state();
      return {m_valid, m_rs, m_rt, m_wr, m_rw, m_mr, m_mw, m_alu, m_rsd, m_rtd, m_imm, m_cnt};
   endfunction

   task automatic model_clear_ex();
      m_valid = 0; m_rs = 0; m_rt = 0; m_wr = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      m_alu = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
   endtask

   // One clock: check combinational stall outputs, predict, then compare after the edge.
   task automatic cycle();
      logic lu, exp_stall_n;
      lu = m_valid && m_mr && (m_wr != 0) && id_valid &&
           ((m_wr == id_rs) || (id_uses_rt && (m_wr == id_rt)));
      if (rst)               exp_stall_n = 1'b1;
      else if (ex_hold)      exp_stall_n = 1'b0;
      else if (flush || m_fp) exp_stall_n = 1'b1;
      else if (lu)           exp_stall_n = 1'b0;
      else                   exp_stall_n = 1'b1;
      @(negedge clk);
      check("pc_write", SW'(pc_write), SW'(exp_stall_n));
      check("if_id_write", SW'(if_id_write), SW'(exp_stall_n));
      if (rst) begin
         model_clear_ex(); m_cnt = 0; m_fp = 0;
      end else if (ex_hold) begin
         if (flush) m_fp = 1;
      end else if (flush || m_fp || lu) begin
         model_clear_ex(); m_fp = 0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (id_valid) begin
         m_valid = 1; m_rs = id_rs; m_rt = id_rt; m_wr = id_write_reg; m_rw = id_reg_write;
         m_mr = id_mem_read; m_mw = id_mem_write; m_alu = id_alu_op;
         m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end else begin
         model_clear_ex();
      end
      exp_q.push_back(model_state());
      @(posedge clk);
      #1;
      check("ex_state", dut_state(), exp_q.pop_front());
   endtask

   // driver tasks
   task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                            input logic [4:0] wr, input logic rw, input logic mr,
                            input logic mw, input logic [3:0] alu);
      id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_write_reg = wr;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_op = alu;
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
   endtask

   task automatic set_idle();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0);
      id_valid = 0;
   endtask

   task automatic load_then(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urt);
      set_instr(1, 7, 0, wr, 1, 1, 0, 4'h2);   // lw wr
      cycle();
      set_instr(rs, rt, urt, 3, 1, 0, 0, 4'h1);
      #1;
   endtask

   logic [15:0] cnt_before;

   initial begin
      rst = 1; flush = 0; ex_hold = 0;
      set_idle();
      m_cnt = 16'hxxxx; m_fp = 1'bx; model_clear_ex();
      cycle(); cycle();
      rst = 0;
      #1;
      check("reset_pc_write", SW'(pc_write), SW'(1));
      check("reset_ex_valid", SW'(ex_valid), SW'(0));
      check("reset_bubble_cnt", SW'(bubble_cnt), SW'(0));

      // lw $2 ; add $3,$2,$4 -> one stall cycle
      load_then(2, 2, 4, 1);
      check("lu_pc_write", SW'(pc_write), SW'(0));
      check("lu_if_id_write", SW'(if_id_write), SW'(0));
      cycle();
      check("lu_bubble_valid", SW'(ex_valid), SW'(0));
      check("lu_bubble_cnt", SW'(bubble_cnt), SW'(1));
      check("lu_resume_pc_write", SW'(pc_write), SW'(1));
      cycle();
      check("lu_add_ex_rs", SW'(ex_rs), SW'(2));
      check("lu_add_valid", SW'(ex_valid), SW'(1));

      // lw $2 ; addi $3,$5,4 with rt=2 but rt unused -> no stall
      load_then(2, 5, 2, 0);
      check("addi_pc_write", SW'(pc_write), SW'(1));
      cycle();
      check("addi_bubble_cnt", SW'(bubble_cnt), SW'(1));

      // lw $0 ; add $3,$0,$0 -> no stall
      load_then(0, 0, 0, 1);
      check("zero_pc_write", SW'(pc_write), SW'(1));
      cycle();
      check("zero_ex_valid", SW'(ex_valid), SW'(1));

      // flush coincident with load-use -> a single bubble, fetch allowed
      load_then(2, 2, 4, 1);
      flush = 1;
      #1;
      check("flush_lu_pc_write", SW'(pc_write), SW'(1));
      cycle();
      flush = 0;
      check("flush_lu_cnt", SW'(bubble_cnt), SW'(2));
      check("flush_lu_valid", SW'(ex_valid), SW'(0));

      // hold for 3 cycles with a flush pulse in the middle cycle
      set_instr(1, 7, 0, 9, 1, 1, 0, 4'h2);
      cycle();
      cnt_before = m_cnt;
      set_instr(4, 5, 1, 6, 1, 0, 0, 4'h3);
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         flush = (i == 1);
         #1;
         check("hold_pc_write", SW'(pc_write), SW'(0));
         cycle();
         check("hold_frozen_wr", SW'(ex_write_reg), SW'(9));
      end
      ex_hold = 0; flush = 0;
      #1;
      check("pend_pc_write", SW'(pc_write), SW'(1));
      cycle();
      check("pend_bubble_valid", SW'(ex_valid), SW'(0));
      check("pend_bubble_cnt", SW'(bubble_cnt), SW'(cnt_before + 16'd1));

      // randomised traffic over a small register range to hit hazards often
      for (int i = 0; i < 400; i++) begin
         set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         id_valid = ($urandom_range(0, 4) != 0);
         flush    = ($urandom_range(0, 7) == 0);
         ex_hold  = ($urandom_range(0, 5) == 0);
         cycle();
      end
      flush = 0; ex_hold = 0;
      set_idle();
      cycle();

      // saturate the counter using back-to-back flush bubbles
      flush = 1;
      for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) cycle();
      flush = 0;
      check("sat_reached", SW'(bubble_cnt), SW'(16'hFFFF));
      load_then(2, 2, 4, 1);
      cycle();
      check("sat_hold_cnt", SW'(bubble_cnt), SW'(16'hFFFF));
      check("sat_bubble_valid", SW'(ex_valid), SW'(0));

      // reset while a load-use stall is active
      set_idle();
      cycle();
      load_then(2, 2, 4, 1);
      check("pre_rst_stall", SW'(pc_write), SW'(0));
      rst = 1;
      #1;
      check("rst_forces_pc_write", SW'(pc_write), SW'(1));
      cycle();
      rst = 0;
      set_idle();
      #1;
      check("rst_ex_valid", SW'(ex_valid), SW'(0));
      check("rst_ex_write_reg", SW'(ex_write_reg), SW'(0));
      check("rst_bubble_cnt", SW'(bubble_cnt), SW'(0));
      check("rst_pc_write", SW'(pc_write), SW'(1));
      cycle();

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
